// File: rtl/clock_display_scan.sv
// clock_display_scan: samples binary seconds/minutes on each seconds change,
// converts them to BCD and scans a 4-digit common-anode 7-segment display
// (MM.SS) with a separator dot that blinks once per seconds update.
module clock_display_scan #(
    parameter int SCAN_DIV = 4,
    parameter int W        = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] seconds,
    input  logic [W-1:0] minutes,
    output logic [6:0]   seg,
    output logic [3:0]   an,
    output logic         dp
);

    localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [6:0]       SEG_DASH = 7'b0111111;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one decimal digit.
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = SEG_DASH;
        endcase
    endfunction

    logic [W-1:0]     prev_sec_q, prev_sec_d;
    logic [W-1:0]     sec_q, sec_d;
    logic [W-1:0]     min_q, min_d;
    logic             blink_q, blink_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;
    logic             dp_q, dp_d;
    logic [6:0]       digit_code;

    // Field 0 is the seconds snapshot, field 1 the minutes snapshot. Each is
    // split into tens/units; an out-of-range value blanks both digits to dash.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_field
            logic [W-1:0] value;
            logic [31:0]  value_ext;
            logic         in_range;
            logic [3:0]   tens;
            logic [3:0]   units;
            logic [6:0]   tens_code;
            logic [6:0]   units_code;

            assign value = (gi == 0) ? sec_q : min_q;

            // Binary to BCD split of one snapshot field.
            always_comb begin
                value_ext = 32'(value);
                in_range  = (value_ext <= 32'd59);
                tens      = 4'(value_ext / 32'd10);
                units     = 4'(value_ext % 32'd10);
            end

            assign tens_code  = in_range ? seg_code(tens)  : SEG_DASH;
            assign units_code = in_range ? seg_code(units) : SEG_DASH;
        end
    endgenerate

    // Pick the segment pattern for the digit currently being scanned.
    always_comb begin
        digit_code = g_field[1].tens_code;
        case (idx_q)
            2'd0:    digit_code = g_field[0].units_code;
            2'd1:    digit_code = g_field[0].tens_code;
            2'd2:    digit_code = g_field[1].units_code;
            default: digit_code = g_field[1].tens_code;
        endcase
    end

    // Next-state: snapshot on seconds change, scan divider/index, pin values.
    always_comb begin
        prev_sec_d = seconds;
        sec_d      = sec_q;
        min_d      = min_q;
        blink_d    = blink_q;
        // Minutes are only taken together with seconds so MM and SS never tear.
        if (seconds != prev_sec_q) begin
            sec_d   = seconds;
            min_d   = minutes;
            blink_d = ~blink_q;
        end

        if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            div_d = div_q + DIV_W'(1);
            idx_d = idx_q;
        end

        an_d  = ~(4'b0001 << idx_q);
        seg_d = digit_code;
        dp_d  = ~((idx_q == 2'd2) && blink_q);
    end

    // All state and the registered pin drivers, with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_sec_q <= '0;
            sec_q      <= '0;
            min_q      <= '0;
            blink_q    <= 1'b0;
            div_q      <= '0;
            idx_q      <= 2'd0;
            seg_q      <= 7'b1111111;
            an_q       <= 4'b1111;
            dp_q       <= 1'b1;
        end else begin
            prev_sec_q <= prev_sec_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            blink_q    <= blink_d;
            div_q      <= div_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            dp_q       <= dp_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Testbench for clock_display_scan: directed scenarios plus randomized
// seconds/minutes/reset traffic, checked against a cycle-count based model.
module tb_clock_display_scan;

    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] seconds = 6'd0;
    logic [5:0] minutes = 6'd0;
    logic [6:0] seg, seg1;
    logic [3:0] an, an1;
    logic       dp, dp1;

    int compared = 0;
    int mismatched = 0;

    // Reference model: display content by digit position, scan position from
    // the number of edges since reset release.
    int         m_cnt, m_prev, m_sec, m_min;
    bit         m_blink;
    logic [3:0] e_an, e_an1;
    logic [6:0] e_seg, e_seg1;
    logic       e_dp, e_dp1;

    clock_display_scan #(.SCAN_DIV(SD), .W(6)) dut (
        .clk(clk), .reset(reset), .seconds(seconds), .minutes(minutes),
        .seg(seg), .an(an), .dp(dp)
    );

    clock_display_scan #(.SCAN_DIV(1), .W(6)) dut1 (
        .clk(clk), .reset(reset), .seconds(seconds), .minutes(minutes),
        .seg(seg1), .an(an1), .dp(dp1)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] code_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Digit position 0..3 -> seconds units, seconds tens, minutes units, minutes tens.
    function automatic logic [6:0] disp(input int pos);
        int v;
        v = (pos < 2) ? m_sec : m_min;
        if (v > 59) return 7'b0111111;
        return code_of((pos % 2 == 0) ? (v % 10) : (v / 10));
    endfunction

    // Advance one clock edge and update the expected pin values.
    task automatic step();
        int i;
        @(posedge clk);
        if (reset) begin
            m_cnt = 0; m_prev = 0; m_sec = 0; m_min = 0; m_blink = 0;
            e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
            e_an1 = 4'b1111; e_seg1 = 7'b1111111; e_dp1 = 1'b1;
        end else begin
            i = (m_cnt / SD) % 4;
            e_an = ~(4'b0001 << i); e_seg = disp(i); e_dp = (i == 2 && m_blink) ? 1'b0 : 1'b1;
            i = m_cnt % 4;
            e_an1 = ~(4'b0001 << i); e_seg1 = disp(i); e_dp1 = (i == 2 && m_blink) ? 1'b0 : 1'b1;
            if (int'(seconds) != m_prev) begin
                m_sec = int'(seconds);
                m_min = int'(minutes);
                m_blink = !m_blink;
            end
            m_prev = int'(seconds);
            m_cnt++;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; seconds = 6'd0; minutes = 6'd0;
        for (int c = 0; c < 3; c++) begin
            step();
            compared++;
            if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
                mismatched++;
                $display("FAIL reset_state c%0d: an=%b seg=%b dp=%b, expected an=1111 seg=1111111 dp=1", c, an, seg, dp);
            end
        end
    endtask

    task automatic test_scan_order();
        logic [3:0] want [5];
        want[0] = 4'b1110; want[1] = 4'b1101; want[2] = 4'b1011; want[3] = 4'b0111; want[4] = 4'b1110;
        reset = 1'b0; seconds = 6'd0; minutes = 6'd0;
        for (int c = 0; c <= 4 * SD; c++) begin
            step();
            if (c == 0) begin
                compared++;
                if (seg !== 7'b1000000) begin
                    mismatched++;
                    $display("FAIL first_digit: seg=%b, expected 1000000", seg);
                end
            end
            if (c % SD == 0) begin
                compared++;
                if (an !== want[c / SD]) begin
                    mismatched++;
                    $display("FAIL scan_order edge%0d: an=%b, expected %b", c, an, want[c / SD]);
                end
            end
            compared++;
            if (an !== e_an || seg !== e_seg || dp !== e_dp) begin
                mismatched++;
                $display("FAIL scan_model c%0d: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b", c, an, seg, dp, e_an, e_seg, e_dp);
            end
        end
    endtask

    // Run a full scan and compare each digit with fixed expected patterns.
    task automatic check_digits(input string name, input logic [6:0] w0, input logic [6:0] w1,
                                input logic [6:0] w2, input logic [6:0] w3, input int cycles);
        logic [6:0] obs [4];
        logic [6:0] want [4];
        want[0] = w0; want[1] = w1; want[2] = w2; want[3] = w3;
        for (int k = 0; k < 4; k++) obs[k] = 7'bx;
        for (int c = 0; c < cycles; c++) begin
            step();
            for (int k = 0; k < 4; k++) if (an === ~(4'b0001 << k)) obs[k] = seg;
            compared++;
            if (an !== e_an || seg !== e_seg || dp !== e_dp) begin
                mismatched++;
                $display("FAIL %s_model c%0d: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b", name, c, an, seg, dp, e_an, e_seg, e_dp);
            end
        end
        for (int k = 0; k < 4; k++) begin
            compared++;
            if (obs[k] !== want[k]) begin
                mismatched++;
                $display("FAIL %s_digit%0d: seg=%b, expected %b", name, k, obs[k], want[k]);
            end
        end
    endtask

    task automatic test_digits();
        seconds = 6'd37; minutes = 6'd12;
        step(); step();
        check_digits("digits", 7'b1111000, 7'b0110000, 7'b0100100, 7'b1111001, 4 * SD + 2);
    endtask

    task automatic test_rollover();
        reset = 1'b1; seconds = 6'd0; minutes = 6'd4;
        step(); step();
        reset = 1'b0;
        step();
        seconds = 6'd58;
        for (int c = 0; c < 5; c++) step();
        seconds = 6'd59;
        for (int c = 0; c < 6; c++) begin
            step();
            if (c == 2) minutes = 6'd5;   // minutes move early; must stay hidden
            compared++;
            if (an !== e_an || seg !== e_seg || dp !== e_dp) begin
                mismatched++;
                $display("FAIL rollover_model c%0d: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b", c, an, seg, dp, e_an, e_seg, e_dp);
            end
        end
        seconds = 6'd0;
        step(); step();
        check_digits("rollover", 7'b1000000, 7'b1000000, 7'b0010010, 7'b1000000, 4 * SD + 2);
        // Three seconds changes -> separator dot lit on the minutes-units digit.
        for (int c = 0; c < 4 * SD; c++) begin
            step();
            compared++;
            if (dp !== ((an === 4'b1011) ? 1'b0 : 1'b1)) begin
                mismatched++;
                $display("FAIL rollover_dp c%0d: an=%b dp=%b, expected dp=%b", c, an, dp, (an === 4'b1011) ? 1'b0 : 1'b1);
            end
        end
    endtask

    task automatic test_dash();
        minutes = 6'd63; seconds = 6'd9;
        step(); step();
        check_digits("dash", 7'b0010000, 7'b1000000, 7'b0111111, 7'b0111111, 4 * SD + 2);
    endtask

    task automatic test_div1();
        logic [3:0] want [5];
        want[0] = 4'b1110; want[1] = 4'b1101; want[2] = 4'b1011; want[3] = 4'b0111; want[4] = 4'b1110;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            compared++;
            if (an1 !== want[c] || seg1 !== e_seg1 || dp1 !== e_dp1) begin
                mismatched++;
                $display("FAIL div1 c%0d: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b", c, an1, seg1, dp1, want[c], e_seg1, e_dp1);
            end
        end
    endtask

    task automatic test_reset_mid();
        int budget;
        seconds = 6'd45;
        budget = 0;
        step();
        while (an !== 4'b1011 && budget < 40) begin
            step();
            budget++;
        end
        compared++;
        if (an !== 4'b1011) begin
            mismatched++;
            $display("FAIL reset_mid_wait: an=%b, expected 1011 within 40 cycles", an);
        end
        step();   // mid-window
        reset = 1'b1;
        step();
        compared++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_mid_assert: an=%b seg=%b dp=%b, expected an=1111 seg=1111111 dp=1", an, seg, dp);
        end
        step();
        reset = 1'b0;
        step();
        compared++;
        if (an !== 4'b1110 || seg !== 7'b1000000) begin
            mismatched++;
            $display("FAIL reset_mid_restart: an=%b seg=%b, expected an=1110 seg=1000000", an, seg);
        end
        step();
        compared++;
        if (an !== 4'b1110 || seg !== 7'b0010010) begin
            mismatched++;
            $display("FAIL reset_mid_update: an=%b seg=%b, expected an=1110 seg=0010010", an, seg);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) seconds = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) minutes = 6'($urandom_range(0, 63));
            reset = ($urandom_range(0, 99) == 0);
            step();
            compared++;
            if (an !== e_an || seg !== e_seg || dp !== e_dp) begin
                mismatched++;
                $display("FAIL random c%0d: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b", c, an, seg, dp, e_an, e_seg, e_dp);
            end
            compared++;
            if (an1 !== e_an1 || seg1 !== e_seg1 || dp1 !== e_dp1) begin
                mismatched++;
                $display("FAIL random_div1 c%0d: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b", c, an1, seg1, dp1, e_an1, e_seg1, e_dp1);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_digits();
        test_rollover();
        test_dash();
        test_div1();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/clock_display_scan.md
Name: clock_display_scan

Overview:
Reader side of the digital_clock time outputs. Samples the binary seconds/minutes values and converts each to two BCD digits. Drives a 4-digit, time-multiplexed, common-anode 7-segment display (MM.SS), with a blinking separator dot that toggles on every seconds update. Sits between digital_clock and the board display pins, on the same clock.

Parameters:
SCAN_DIV, 4, clock cycles each digit stays enabled before the scan advances (legal range >= 1)
W, 6, width of the seconds/minutes inputs

Ports:
clk      input   1   system clock, same clock as digital_clock
reset    input   1   synchronous, active-high reset
seconds  input   W   binary seconds from digital_clock, 0..59 legal
minutes  input   W   binary minutes from digital_clock, 0..59 legal
seg      output  7   active-low segments, bit order {g,f,e,d,c,b,a}
an       output  4   active-low digit enables; an[0]=sec units, an[1]=sec tens, an[2]=min units, an[3]=min tens
dp       output  1   active-low decimal point (separator)

Behaviour:
- Reset: this is the only reset; it is synchronous, active-high, and sampled on the clk rising edge.
  - Outputs: an=4'b1111, seg=7'b1111111, dp=1.
  - Internal state: sec_q=0, min_q=0, prev_sec=0, blink=0, div=0, idx=0.
  - Reset asserted mid-scan returns everything to these values on the next edge. No partial digit survives.
- Snapshot:
  - prev_sec <= seconds every cycle.
  - When seconds != prev_sec (change detect), sec_q <= seconds, min_q <= minutes, and blink toggles, all on the same edge.
  - Otherwise sec_q, min_q and blink hold. Minutes are captured only together with seconds, so a display cannot tear between them.
- Scan counter:
  - div counts 0..SCAN_DIV-1.
  - At div==SCAN_DIV-1, div wraps to 0 and idx advances 0->1->2->3->0.
  - With SCAN_DIV=1, idx advances every cycle.
- Digit select from idx: 0 = sec_q units, 1 = sec_q tens, 2 = min_q units, 3 = min_q tens.
- BCD conversion (combinational): tens = v/10, units = v%10, for v in 0..59.
  - Any v > 59 makes both digits of that field show dash (7'b0111111).
  - The other field is unaffected.
- Segment codes (active-low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, dash=0111111
- Output register: an, seg and dp are registered from the current idx and snapshot.
  - an = ~(1<<idx).
  - dp=0 only when idx==2 and blink==1; otherwise dp=1.
  - Latency is one cycle from idx/snapshot to pins. The first edge after reset release drives an=1110 with the code for 0.
  - Exactly one an bit is low at any time outside reset.
- Timing of updates:
  - A snapshot update during a digit's window takes effect on the next output register update. The scan is not realigned.
  - A seconds change and a scan wrap on the same edge are both applied independently.
- No leading-zero blanking: minutes tens always shows its digit.

Test Plan:
- Reset held 3 cycles, then released with seconds=0, minutes=0 -> during reset an=1111, seg=1111111, dp=1. Next edge: an=1110, seg=1000000. After SCAN_DIV cycles: an=1101, then 1011, then 0111, then 1110.
- seconds=37, minutes=12 applied after reset -> over one full scan, digit 0 shows 7 (1111000), digit 1 shows 3 (0110000), digit 2 shows 2 (0100100), digit 3 shows 1 (1111001).
- seconds steps 58->59->0 with minutes 4->5 on the wrap -> after the third change, digits read 0,0,5,0. blink has toggled three times, so dp is low on an[2] (blink=1 after an odd count). Minutes never appear updated before seconds.
- minutes=63, seconds=9 -> digits 2 and 3 show dash (0111111); digits 0 and 1 show 9 and 0.
- SCAN_DIV=1 build -> an rotates every cycle: 1110, 1101, 1011, 0111, 1110.
- Reset asserted while idx=2 mid-window with seconds=45 -> next edge an=1111, dp=1. After release the scan restarts at an=1110. Display shows 0 until seconds next changes, then 5 on digit 0.
